// File: rtl/osd_dii_tx.sv
// rtl/osd_dii_tx.sv - DII packet transmitter: serializes one debug packet request into ring flits
package osd_dii_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module osd_dii_tx #(
  parameter int MAX_PAYLOAD = 8,
  parameter int LW = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 id,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [15:0]                 req_dest,
  input  logic [1:0]                  req_type,
  input  logic [3:0]                  req_type_sub,
  input  logic [LW-1:0]               req_len,
  input  logic [MAX_PAYLOAD*16-1:0]   req_payload,
  output osd_dii_pkg::dii_flit        dii_out,
  input  logic                        dii_out_ready,
  output logic                        busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DEST    = 3'd1;
  localparam logic [2:0] SRC     = 3'd2;
  localparam logic [2:0] FLAGS   = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;

  logic [2:0]                state;
  logic [15:0]               dest_q;
  logic [15:0]               src_q;
  logic [1:0]                type_q;
  logic [3:0]                type_sub_q;
  logic [LW-1:0]             len_q;
  logic [LW-1:0]             idx;
  logic [LW-1:0]             len_sat;
  logic [LW-1:0]             last_idx;
  logic [MAX_PAYLOAD*16-1:0] payload_q;
  logic                      hs;

  assign len_sat   = (req_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : req_len;
  assign last_idx  = len_q - LW'(1);
  assign hs        = dii_out.valid & dii_out_ready;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Payload is held as a shift register: the word on the wire is always the low 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      type_sub_q <= '0;
      len_q      <= '0;
      payload_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dest_q     <= req_dest;
            src_q      <= id;
            type_q     <= req_type;
            type_sub_q <= req_type_sub;
            len_q      <= len_sat;
            payload_q  <= req_payload;
            idx        <= '0;
            state      <= DEST;
          end
        end
        DEST:  if (hs) state <= SRC;
        SRC:   if (hs) state <= FLAGS;
        FLAGS: begin
          if (hs) begin
            idx   <= '0;
            state <= (len_q == '0) ? IDLE : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (hs) begin
            payload_q <= payload_q >> 16;
            if (idx == last_idx) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + LW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flit is a pure function of registered state, so it cannot change while stalled.
  always_comb begin
    dii_out = '0;
    case (state)
      DEST: begin
        dii_out.valid = 1'b1;
        dii_out.data  = dest_q;
      end
      SRC: begin
        dii_out.valid = 1'b1;
        dii_out.data  = src_q;
      end
      FLAGS: begin
        dii_out.valid = 1'b1;
        dii_out.data  = {type_q, type_sub_q, 10'b0};
        dii_out.last  = (len_q == '0);
      end
      PAYLOAD: begin
        dii_out.valid = 1'b1;
        dii_out.data  = payload_q[15:0];
        dii_out.last  = (idx == last_idx);
      end
      default: dii_out = '0;
    endcase
  end

endmodule

// File: tb/tb_osd_dii_tx.sv
// tb/tb_osd_dii_tx.sv - directed self-checking bench for osd_dii_tx
module tb_osd_dii_tx;
  localparam int MAXP = 8;
  localparam int LW   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          id;
  logic                 req_valid;
  logic                 req_ready;
  logic [15:0]          req_dest;
  logic [1:0]           req_type;
  logic [3:0]           req_type_sub;
  logic [LW-1:0]        req_len;
  logic [MAXP*16-1:0]   req_payload;
  osd_dii_pkg::dii_flit dii_out;
  logic                 dii_out_ready;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic [15:0] got_d[$];
  logic        got_l[$];
  logic [15:0] exp_d[$];
  logic        exp_l[$];
  logic [MAXP*16-1:0] pl;

  osd_dii_tx #(.MAX_PAYLOAD(MAXP), .LW(LW)) dut (
    .clk(clk), .rst(rst), .id(id), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_type(req_type), .req_type_sub(req_type_sub),
    .req_len(req_len), .req_payload(req_payload), .dii_out(dii_out),
    .dii_out_ready(dii_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [15:0] dest, input logic [15:0] src, input logic [1:0] t,
                          input logic [3:0] ts, input logic [LW-1:0] len, input logic [MAXP*16-1:0] p);
    req_dest = dest; id = src; req_type = t; req_type_sub = ts; req_len = len; req_payload = p;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Drives dii_out_ready from pattern (then 1), records handshaken flits, checks stall stability.
  task automatic run_pkt(input logic [15:0] pattern, input int plen);
    bit done = 0;
    bit holding = 0;
    logic [16:0] held = '0;
    got_d.delete(); got_l.delete(); cycles = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      dii_out_ready = (c < plen) ? pattern[c] : 1'b1;
      #1;
      if (holding)
        check("stall_hold", {14'b0, dii_out.valid, dii_out.last, dii_out.data}, {14'b0, 1'b1, held});
      holding = 0;
      if (dii_out.valid) begin
        cycles = c + 1;
        if (dii_out_ready) begin
          got_d.push_back(dii_out.data);
          got_l.push_back(dii_out.last);
          if (dii_out.last) done = 1;
        end else begin
          holding = 1;
          held = {dii_out.last, dii_out.data};
        end
      end
      @(negedge clk);
    end
    if (!done) check("pkt_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_seq(input string tag);
    check({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), {16'b0, got_d[i]}, {16'b0, exp_d[i]});
      check($sformatf("%s_last%0d", tag, i), {31'b0, got_l[i]}, {31'b0, exp_l[i]});
    end
  endtask

  task automatic idle_check(input string tag);
    #1;
    check({tag, "_valid"}, {31'b0, dii_out.valid}, 32'd0);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; id = '0; req_dest = '0; req_type = '0; req_type_sub = '0;
    req_len = '0; req_payload = '0; dii_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    idle_check("reset");
    check("reset_last", {31'b0, dii_out.last}, 32'd0);
    check("reset_data", {16'b0, dii_out.data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Length 0 packet
    send_req(16'h0005, 16'h0001, 2'd2, 4'd3, 4'd0, '0);
    check("len0_busy", {31'b0, busy}, 32'd1);
    check("len0_req_ready", {31'b0, req_ready}, 32'd0);
    run_pkt(16'hFFFF, 0);
    exp_d = '{16'h0005, 16'h0001, 16'h8C00};
    exp_l = '{1'b0, 1'b0, 1'b1};
    cmp_seq("len0");
    check("len0_cycles", cycles, 32'd3);
    idle_check("len0_after");

    // Length 3 packet
    pl = '0;
    pl[47:0] = {16'hC3C3, 16'hB2B2, 16'hA1A1};
    send_req(16'h0022, 16'h0010, 2'd1, 4'hA, 4'd3, pl);
    run_pkt(16'hFFFF, 0);
    exp_d = '{16'h0022, 16'h0010, 16'h6800, 16'hA1A1, 16'hB2B2, 16'hC3C3};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmp_seq("len3");
    check("len3_cycles", cycles, 32'd6);
    idle_check("len3_after");

    // Backpressure: ready pattern 1,0,0,1,0,1,1 then 1
    pl = '0;
    pl[31:0] = {16'hBEEF, 16'hDEAD};
    send_req(16'h1234, 16'h0042, 2'd3, 4'hF, 4'd2, pl);
    run_pkt(16'h0069, 7);
    exp_d = '{16'h1234, 16'h0042, 16'hFC00, 16'hDEAD, 16'hBEEF};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmp_seq("bp");
    check("bp_cycles", cycles, 32'd8);
    idle_check("bp_after");

    // Max length, then over-length (saturates) with request inputs disturbed mid-packet
    pl = '0;
    for (int i = 0; i < MAXP; i++) pl[i*16 +: 16] = 16'h1000 + 16'(i);
    exp_d = '{16'h0300, 16'h0007, 16'h0400};
    exp_l = '{1'b0, 1'b0, 1'b0};
    for (int i = 0; i < MAXP; i++) begin
      exp_d.push_back(16'h1000 + 16'(i));
      exp_l.push_back(i == MAXP - 1);
    end
    send_req(16'h0300, 16'h0007, 2'd0, 4'd1, 4'd8, pl);
    run_pkt(16'hFFFF, 0);
    cmp_seq("max");
    check("max_cycles", cycles, 32'd11);

    send_req(16'h0300, 16'h0007, 2'd0, 4'd1, 4'd9, pl);
    req_dest = 16'hFFFF; req_len = 4'd2; req_payload = '0; id = 16'hEEEE; req_valid = 1'b1;
    run_pkt(16'hFFFF, 0);
    req_valid = 1'b0;
    cmp_seq("sat");
    check("sat_cycles", cycles, 32'd11);
    idle_check("sat_after");

    // Reset during 2nd payload flit of a length-4 packet
    pl = '0;
    pl[63:0] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    dii_out_ready = 1'b1;
    send_req(16'h0AAA, 16'h0BBB, 2'd2, 4'd0, 4'd4, pl);
    repeat (4) @(negedge clk);
    #1;
    check("mid_p1_data", {16'b0, dii_out.data}, 32'h2222);
    rst = 1'b1;
    @(negedge clk);
    idle_check("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    send_req(16'h0009, 16'h0003, 2'd1, 4'd5, 4'd0, '0);
    run_pkt(16'hFFFF, 0);
    exp_d = '{16'h0009, 16'h0003, 16'h5400};
    exp_l = '{1'b0, 1'b0, 1'b1};
    cmp_seq("post_rst");
    check("post_rst_cycles", cycles, 32'd3);
    idle_check("post_rst_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
